// File: rtl/jtdd_scroll_layer.sv
// Tile-map scroll layer: CPU-visible map RAM, wrapped scroll, ROM row fetch FSM
// and a double-buffered tile row feeding one {pal,pixel} per pxl_cen.
module jtdd_scroll_layer #(
    parameter int TW    = 3,
    parameter int MAPW  = 5,
    parameter int MAPH  = 5,
    parameter int CODEW = 10,
    parameter int PALW  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pxl_cen,
    input  logic [MAPW+MAPH:0]       cpu_addr,
    input  logic [7:0]               cpu_dout,
    input  logic                     scr_cs,
    input  logic                     cpu_wrn,
    output logic [7:0]               scr_dout,
    input  logic [8:0]               hpos,
    input  logic [8:0]               vpos,
    input  logic [MAPW+TW-1:0]       scrhpos,
    input  logic [MAPH+TW-1:0]       scrvpos,
    input  logic                     flip,
    output logic [CODEW+2*TW-3:0]    rom_addr,
    output logic                     rom_cs,
    input  logic [15:0]              rom_data,
    input  logic                     rom_ok,
    output logic [PALW+3:0]          scr_pxl,
    output logic                     underrun
);
    localparam int HW    = MAPW + TW;
    localparam int VW    = MAPH + TW;
    localparam int AW    = MAPW + MAPH;
    localparam int KW    = TW - 2;
    localparam int WORDS = 1 << KW;
    localparam int HSW   = (HW > 9) ? HW : 9;
    localparam int VSW   = (VW > 9) ? VW : 9;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAP  = 2'd1;
    localparam logic [1:0] ST_MAPW = 2'd2;
    localparam logic [1:0] ST_ROM  = 2'd3;

    localparam logic [MAPW-1:0] COL_ONE = 1;
    localparam logic [KW-1:0]   K_ONE   = 1;
    localparam logic [KW-1:0]   K_LAST  = '1;

    // Map RAM kept as two byte lanes so CPU byte writes never touch the other half
    logic [7:0]  ram_hi [0:(1<<AW)-1];
    logic [7:0]  ram_lo [0:(1<<AW)-1];
    logic [AW-1:0] cpu_wa;
    logic [AW-1:0] scan_addr;
    logic [15:0] scan_q;

    logic [HW-1:0]   hscr;
    logic [VW-1:0]   vscr;
    logic            trig;
    logic [1:0]      state;
    logic [MAPW-1:0] f_col;
    logic [MAPH-1:0] f_row;
    logic [TW-1:0]   f_line;
    logic [KW-1:0]   k;
    logic            addr_chg;
    logic            cur_sel, cur_vld, nxt_vld;
    logic            wsel;
    logic            store;

    logic [1:0][WORDS-1:0][15:0] row_buf;
    logic [1:0][PALW-1:0]        buf_pal;
    logic [1:0]                  buf_hf;

    logic            use_sel, use_vld;
    logic [TW-1:0]   pix_i;
    logic [15:0]     pix_w;
    logic [3:0]      pix_px;

    assign cpu_wa    = cpu_addr[AW:1];
    assign scan_addr = {f_row, f_col};
    assign trig      = pxl_cen && (hscr[TW-1:0] == '0);
    assign wsel      = ~cur_sel;
    assign store     = (state == ST_ROM) && rom_ok && !addr_chg;

    always_ff @(posedge clk) begin
        if (scr_cs && !cpu_wrn) begin
            if (cpu_addr[0]) ram_lo[cpu_wa] <= cpu_dout;
            else             ram_hi[cpu_wa] <= cpu_dout;
        end
        scan_q <= {ram_hi[scan_addr], ram_lo[scan_addr]};
    end

    always_ff @(posedge clk) begin
        if (rst) scr_dout <= 8'd0;
        else     scr_dout <= cpu_addr[0] ? ram_lo[cpu_wa] : ram_hi[cpu_wa];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hscr <= '0;
            vscr <= '0;
        end else if (pxl_cen) begin
            hscr <= HW'(HSW'(hpos) + HSW'(scrhpos));
            vscr <= VW'(VSW'(vpos) + VSW'(scrvpos));
        end
    end

    // On a boundary the pixel must come from the row being promoted this clock
    always_comb begin
        use_sel = cur_sel;
        use_vld = cur_vld;
        if (trig) begin
            use_vld = nxt_vld;
            if (nxt_vld) use_sel = ~cur_sel;
        end
        pix_i  = hscr[TW-1:0] ^ {TW{buf_hf[use_sel]}};
        pix_w  = row_buf[use_sel][pix_i[TW-1:2]];
        pix_px = pix_w[{pix_i[1:0], 2'b00} +: 4];
    end

    always_ff @(posedge clk) begin
        if (!rst && !trig) begin
            if (state == ST_MAPW) begin
                buf_pal[wsel] <= scan_q[15:CODEW+2];
                buf_hf[wsel]  <= scan_q[CODEW] ^ flip;
            end
            if (store) row_buf[wsel][rom_addr[KW-1:0]] <= rom_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rom_cs   <= 1'b0;
            rom_addr <= '0;
            addr_chg <= 1'b0;
            k        <= '0;
            cur_sel  <= 1'b0;
            cur_vld  <= 1'b0;
            nxt_vld  <= 1'b0;
            underrun <= 1'b0;
            scr_pxl  <= '0;
            f_col    <= '0;
            f_row    <= '0;
            f_line   <= '0;
        end else begin
            addr_chg <= 1'b0;
            if (pxl_cen) scr_pxl <= use_vld ? {buf_pal[use_sel], pix_px} : '0;
            // A boundary always wins: any fetch in flight is dropped and restarted
            if (trig) begin
                if (nxt_vld) begin
                    cur_sel <= ~cur_sel;
                    cur_vld <= 1'b1;
                end else begin
                    cur_vld  <= 1'b0;
                    underrun <= 1'b1;
                end
                nxt_vld <= 1'b0;
                rom_cs  <= 1'b0;
                state   <= ST_MAP;
                f_col   <= hscr[HW-1:TW] + COL_ONE;
                f_row   <= vscr[VW-1:TW];
                f_line  <= vscr[TW-1:0];
            end else begin
                case (state)
                    ST_MAP: state <= ST_MAPW;
                    ST_MAPW: begin
                        rom_addr <= {scan_q[CODEW-1:0],
                                     f_line ^ {TW{scan_q[CODEW+1] ^ flip}},
                                     {KW{scan_q[CODEW] ^ flip}}};
                        rom_cs   <= 1'b1;
                        addr_chg <= 1'b1;
                        k        <= '0;
                        state    <= ST_ROM;
                    end
                    ST_ROM: if (store) begin
                        if (k == K_LAST) begin
                            rom_cs  <= 1'b0;
                            nxt_vld <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            k                  <= k + K_ONE;
                            rom_addr[KW-1:0]   <= (k + K_ONE) ^ {KW{buf_hf[wsel]}};
                            addr_chg           <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_jtdd_scroll_layer.sv
// Bench for jtdd_scroll_layer: random map/ROM contents, tile-level reference model,
// directed flip, wrap-around, slow-ROM underrun and CPU port checks.
module tb_jtdd_scroll_layer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pxl_cen = 1'b0;
    logic [10:0] cpu_addr = '0;
    logic [7:0]  cpu_dout = '0;
    logic        scr_cs = 1'b0;
    logic        cpu_wrn = 1'b1;
    logic [7:0]  scr_dout;
    logic [8:0]  hpos = '0;
    logic [8:0]  vpos = '0;
    logic [7:0]  scrhpos = '0;
    logic [7:0]  scrvpos = '0;
    logic        flip = 1'b0;
    logic [13:0] rom_addr;
    logic        rom_cs;
    logic [15:0] rom_data;
    logic        rom_ok;
    logic [7:0]  scr_pxl;
    logic        underrun;

    always #5 clk = ~clk;

    jtdd_scroll_layer dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .scr_cs(scr_cs), .cpu_wrn(cpu_wrn),
        .scr_dout(scr_dout), .hpos(hpos), .vpos(vpos), .scrhpos(scrhpos), .scrvpos(scrvpos),
        .flip(flip), .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data),
        .rom_ok(rom_ok), .scr_pxl(scr_pxl), .underrun(underrun)
    );

    // ROM: data follows the address; rom_ok after rom_delay stable clocks of request
    logic [15:0] rom_mem [0:16383];
    int          rom_delay = 0;
    int          rom_cnt = 0;
    logic [13:0] last_addr = '0;
    always @(posedge clk) begin
        if (!rom_cs || rom_addr != last_addr) rom_cnt <= 0;
        else if (rom_cnt < 1000)              rom_cnt <= rom_cnt + 1;
        last_addr <= rom_addr;
    end
    assign rom_data = rom_mem[rom_addr];
    assign rom_ok   = rom_cs && (rom_delay == 0 || rom_cnt >= rom_delay);

    int tests = 0;
    int fails = 0;
    logic [15:0] mmap [0:1023];
    int m_hs, m_vs, pend_col, pend_row, pend_line, cur_col, cur_row, cur_line;
    bit pend_ok, cur_ok, m_under, fast;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Pixel x of tile (col,row) on the given tile line, from map entry and ROM image
    function automatic logic [7:0] model_px(int col, int row, int line, int x);
        logic [15:0] e, w;
        int code, ln, i, hf, vf;
        e    = mmap[row*32 + col];
        code = int'(e[9:0]);
        hf   = int'(e[10] ^ flip);
        vf   = int'(e[11] ^ flip);
        ln   = (vf != 0) ? 7 - line : line;
        i    = (hf != 0) ? 7 - x : x;
        w    = rom_mem[14'(code*16 + ln*2 + i/4)];
        w    = w >> (4*(i%4));
        return {e[15:12], w[3:0]};
    endfunction

    task automatic cpu_wr(input logic [10:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_dout = d; scr_cs = 1'b1; cpu_wrn = 1'b0;
        @(posedge clk); #1;
        scr_cs = 1'b0; cpu_wrn = 1'b1;
    endtask

    task automatic write_entry(input int idx, input logic [15:0] e);
        mmap[idx] = e;
        cpu_wr(11'(idx*2), e[15:8]);
        cpu_wr(11'(idx*2 + 1), e[7:0]);
    endtask

    task automatic reset_dut(input int sh, input int sv, input int vp, input bit fl, input int dly);
        scrhpos = 8'(sh); scrvpos = 8'(sv); vpos = 9'(vp); flip = fl;
        rom_delay = dly; fast = (dly == 0);
        rst = 1'b1; pxl_cen = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_pxl", scr_pxl, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_rom_cs", rom_cs, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_dout", scr_dout, 0);
        m_hs = 0; m_vs = 0; pend_ok = 0; cur_ok = 0; m_under = 0;
    endtask

    // One pixel: 4 clocks, pxl_cen on the first
    task automatic pix_step(input int hp, output logic [7:0] got);
        logic [7:0] want;
        hpos = 9'(hp); pxl_cen = 1'b1;
        @(posedge clk); #1 pxl_cen = 1'b0;
        if (m_hs % 8 == 0) begin
            cur_ok = pend_ok && fast;
            cur_col = pend_col; cur_row = pend_row; cur_line = pend_line;
            if (!cur_ok) m_under = 1;
            pend_ok = 1;
            pend_col = (m_hs/8 + 1) % 32; pend_row = m_vs/8; pend_line = m_vs % 8;
        end
        want = cur_ok ? model_px(cur_col, cur_row, cur_line, m_hs % 8) : 8'd0;
        m_hs = (hp + int'(scrhpos)) % 256;
        m_vs = (int'(vpos) + int'(scrvpos)) % 256;
        got = scr_pxl;
        chk("scr_pxl", scr_pxl, want);
        chk("underrun", underrun, m_under);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] g;
        int sh, s0, h0;
        for (int i = 0; i < 16384; i++) rom_mem[i] = 16'($urandom);
        rom_mem[48] = 16'h4321;
        reset_dut(0, 0, 0, 0, 0);
        for (int i = 0; i < 1024; i++) write_entry(i, 16'($urandom));

        // Unflipped tile at column 1
        write_entry(1, 16'h5003);
        reset_dut(0, 0, 0, 0, 0);
        pix_step(4, g);
        for (int j = 1; j <= 12; j++) begin
            pix_step(4 + j, g);
            if (j >= 5 && j <= 8) chk("dir_noflip", g, 8'h51 + 8'(j - 5));
        end

        // Same tile with hflip
        write_entry(1, 16'h5403);
        reset_dut(0, 0, 0, 0, 0);
        pix_step(4, g);
        for (int j = 1; j <= 12; j++) begin
            pix_step(4 + j, g);
            if (j >= 9) chk("dir_hflip", g, 8'h54 - 8'(j - 9));
        end

        // Wrap: scrhpos=255, hpos=1 gives hscr=0 showing column 0
        reset_dut(255, 0, 3, 0, 0);
        pix_step(501, g);
        for (int j = 1; j <= 23; j++) begin
            pix_step((501 + j) & 511, g);
            if (((501 + j) & 511) == 2) chk("wrap_col0", g, model_px(0, 0, 3, 0));
        end

        // Slow ROM: every fetch is cut short by the next boundary
        reset_dut(0, 0, 0, 0, 20);
        pix_step(4, g);
        for (int j = 1; j <= 20; j++) pix_step(4 + j, g);
        chk("slow_underrun", underrun, 1);

        for (int n = 0; n < 4; n++) begin
            sh = int'($urandom_range(0, 255));
            reset_dut(sh, int'($urandom_range(0, 255)), int'($urandom_range(0, 511)),
                      1'($urandom), 0);
            s0 = int'($urandom_range(0, 31)) * 8 + 4;
            h0 = (s0 - sh) & 511;
            pix_step(h0, g);
            for (int j = 1; j <= 40; j++) pix_step((h0 + j) & 511, g);
        end

        // CPU port
        cpu_wr(11'h001, 8'hAB);
        mmap[0][7:0] = 8'hAB;
        cpu_addr = 11'h001; scr_cs = 1'b1; cpu_wrn = 1'b1;
        @(posedge clk); #1 chk("cpu_rd", scr_dout, 8'hAB);
        cpu_dout = 8'hCD; cpu_wrn = 1'b0;
        @(posedge clk); #1 chk("cpu_rdw_old", scr_dout, 8'hAB);
        cpu_wrn = 1'b1;
        @(posedge clk); #1 chk("cpu_rd_new", scr_dout, 8'hCD);
        cpu_addr = 11'h000;
        @(posedge clk); #1 chk("cpu_rd_hi", scr_dout, mmap[0][15:8]);
        scr_cs = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
